// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch FSM state type.
package cpu_pkg;
   localparam int          XLEN        = 32;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam int          INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/mux2.sv
// Generic 2:1 mux cell: y = sel ? b : a.
module mux2 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sel_i,
   output logic [W-1:0] y_o
);
   assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: hold, pc+4, redirect_pc or pend_pc.
module pc_reg import cpu_pkg::*; #(
   parameter int              XLEN     = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            take_tgt_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic [XLEN-1:0] pend_pc_i,
   output logic [XLEN-1:0] pc_o
);
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_inc, tgt_raw, tgt, seq_or_tgt;

   assign pc_inc = pc_q + XLEN'(INSTR_BYTES);

   // A live redirect beats the pending target captured earlier.
   mux2 #(.W(XLEN)) u_tgt (
      .a_i(pend_pc_i), .b_i(redirect_pc_i), .sel_i(redirect_i), .y_o(tgt_raw)
   );

   // Targets are always word aligned when they enter the pc.
   assign tgt = tgt_raw & ~XLEN'(3);

   mux2 #(.W(XLEN)) u_seq (
      .a_i(pc_inc), .b_i(tgt), .sel_i(take_tgt_i), .y_o(seq_or_tgt)
   );

   mux2 #(.W(XLEN)) u_hold (
      .a_i(pc_q), .b_i(seq_or_tgt), .sel_i(load_i), .y_o(pc_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, registered hand-off to
// decode, and squashing of in-flight responses after a redirect.
module fetch_stage import cpu_pkg::*; #(
   parameter int              XLEN     = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc
);
   fetch_state_t    state_q, state_d;
   logic            squash_q, squash_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            id_valid_q, id_valid_d;
   logic [31:0]     id_instr_q, id_instr_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [XLEN-1:0] pc;
   logic            pc_load, pc_take_tgt;

   pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (pc_load),
      .take_tgt_i   (pc_take_tgt),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .pend_pc_i    (pend_pc_q),
      .pc_o         (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         squash_q   <= 1'b0;
         pend_pc_q  <= '0;
         id_valid_q <= 1'b0;
         id_instr_q <= '0;
         id_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         squash_q   <= squash_d;
         pend_pc_q  <= pend_pc_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      squash_d    = squash_q;
      pend_pc_d   = pend_pc_q;
      id_valid_d  = id_valid_q;
      id_instr_d  = id_instr_q;
      id_pc_d     = id_pc_q;
      pc_load     = 1'b0;
      pc_take_tgt = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = WAIT;
            if (redirect) begin
               pc_load     = 1'b1;
               pc_take_tgt = 1'b1;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               pc_load = 1'b1;
               // Response belongs to the abandoned path: drop it and jump.
               if (redirect || squash_q) begin
                  pc_take_tgt = 1'b1;
                  squash_d    = 1'b0;
               end else begin
                  id_instr_d = imem_rdata;
                  id_pc_d    = pc;
                  id_valid_d = 1'b1;
                  state_d    = HOLD;
               end
            end else if (redirect) begin
               // Request must stay stable, so remember the target for later.
               pend_pc_d = redirect_pc;
               squash_d  = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               id_valid_d  = 1'b0;
               pc_load     = 1'b1;
               pc_take_tgt = 1'b1;
               state_d     = WAIT;
            end else if (id_ready) begin
               id_valid_d = 1'b0;
               state_d    = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_req  = (state_q == WAIT);
   assign imem_addr = pc;
   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc     = id_pc_q;
endmodule
